// File: rtl/stall_sched_l1_l9_if.sv
// Status and clock-gate control bundle between the L1..L9 layers and the stall scheduler.
// master drives layer status and observes gate controls; slave is the scheduler side.
interface stall_sched_l1_l9_if #(
   parameter int NUM_LAYERS = 9
);
   logic [NUM_LAYERS-1:0] in_empty;
   logic [NUM_LAYERS-1:0] out_full;
   logic                  halt;
   logic [NUM_LAYERS-1:0] clk_en;
   logic [NUM_LAYERS-1:0] clk_dis;
   logic [NUM_LAYERS-1:0] stalled;

   modport master (
      output in_empty,
      output out_full,
      output halt,
      input  clk_en,
      input  clk_dis,
      input  stalled
   );

   modport slave (
      input  in_empty,
      input  out_full,
      input  halt,
      output clk_en,
      output clk_dis,
      output stalled
   );
endinterface

// File: rtl/stall_sched_l1_l9.sv
// Central stall scheduler: per-layer stop/restart FSMs with a minimum off time and a
// round-robin restart arbiter that grants at most one clk_en pulse per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | layer clock running; any stall request stops it
//   ST_HOLD  | layer stopped, minimum stall counter still draining
//   ST_READY | layer stopped, requests restart while no stall is pending
module stall_sched_l1_l9 #(
   parameter  int NUM_LAYERS = 9,
   parameter  int MIN_STALL  = 4,
   localparam int CW         = $clog2(MIN_STALL + 1),
   localparam int PW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   stall_sched_l1_l9_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                state_q [NUM_LAYERS];
   state_t                state_d [NUM_LAYERS];
   logic [CW-1:0]         cnt_q   [NUM_LAYERS];
   logic [CW-1:0]         cnt_d   [NUM_LAYERS];
   logic [PW-1:0]         ptr_q;
   logic [PW-1:0]         ptr_d;
   logic [NUM_LAYERS-1:0] clk_en_q;
   logic [NUM_LAYERS-1:0] clk_en_d;
   logic [NUM_LAYERS-1:0] clk_dis_q;
   logic [NUM_LAYERS-1:0] clk_dis_d;
   logic [NUM_LAYERS-1:0] stalled_q;
   logic [NUM_LAYERS-1:0] stalled_d;

   logic [NUM_LAYERS-1:0] stall_req;
   logic [NUM_LAYERS-1:0] req;
   logic [NUM_LAYERS-1:0] gnt;
   logic [PW-1:0]         arb_idx;
   logic                  arb_found;

   assign stall_req = bus.in_empty | bus.out_full | {NUM_LAYERS{bus.halt}};

   // A stall condition in the grant cycle drops req, so the grant is blocked.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         req[i] = (state_q[i] == ST_READY) && !stall_req[i];
      end
   end

   always_comb begin
      gnt       = '0;
      ptr_d     = ptr_q;
      arb_idx   = '0;
      arb_found = 1'b0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         arb_idx = PW'((int'(ptr_q) + k) % NUM_LAYERS);
         if (!arb_found && req[arb_idx]) begin
            gnt[arb_idx] = 1'b1;
            arb_found    = 1'b1;
            ptr_d        = PW'((int'(arb_idx) + 1) % NUM_LAYERS);
         end
      end
   end

   always_comb begin
      clk_en_d  = '0;
      clk_dis_d = '0;
      stalled_d = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_RUN: begin
               if (stall_req[i]) begin
                  clk_dis_d[i] = 1'b1;
                  cnt_d[i]     = CW'(MIN_STALL - 1);
                  state_d[i]   = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end else begin
                  state_d[i] = ST_READY;
               end
            end
            ST_READY: begin
               if (gnt[i]) begin
                  clk_en_d[i] = 1'b1;
                  state_d[i]  = ST_RUN;
               end
            end
            default: begin
               state_d[i] = ST_RUN;
            end
         endcase
         // Stays high through the clk_en cycle even though the FSM is back in RUN.
         stalled_d[i] = (state_d[i] != ST_RUN) || clk_en_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            state_q[i] <= ST_RUN;
            cnt_q[i]   <= '0;
         end
         ptr_q     <= '0;
         clk_en_q  <= '0;
         clk_dis_q <= '0;
         stalled_q <= '0;
      end else begin
         for (int i = 0; i < NUM_LAYERS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         ptr_q     <= ptr_d;
         clk_en_q  <= clk_en_d;
         clk_dis_q <= clk_dis_d;
         stalled_q <= stalled_d;
      end
   end

   assign bus.clk_en  = clk_en_q;
   assign bus.clk_dis = clk_dis_q;
   assign bus.stalled = stalled_q;

endmodule

// File: tb/tb_stall_sched_l1_l9.sv
// Bench for stall_sched_l1_l9: directed scenarios plus sparse random stalls, all
// compared each cycle against a timestamp-based model of stop/restart behaviour.
module tb_stall_sched_l1_l9;
   localparam int N  = 9;
   localparam int MS = 4;
   localparam int LOGN = 4096;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stall_sched_l1_l9_if #(.NUM_LAYERS(N)) ifc ();

   stall_sched_l1_l9 #(.NUM_LAYERS(N), .MIN_STALL(MS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [N-1:0] en_log  [LOGN];
   logic [N-1:0] dis_log [LOGN];

   // model: a layer is either running or stopped since a known cycle
   bit           m_run  [N];
   int           m_stop [N];
   int           m_ptr;
   logic [N-1:0] exp_en;
   logic [N-1:0] exp_dis;
   logic [N-1:0] exp_st;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 1'b1;
         m_stop[i] = 0;
      end
      m_ptr   = 0;
      exp_en  = '0;
      exp_dis = '0;
      exp_st  = '0;
   endtask

   // Predicts the outputs of cycle cyc+1 from the inputs sampled in cycle cyc.
   task automatic model_step(input logic [N-1:0] ie, input logic [N-1:0] of, input logic h);
      logic [N-1:0] want;
      bit           sreq;
      bit           done;
      int           g;
      if (!rst) begin
         model_reset();
         return;
      end
      exp_en  = '0;
      exp_dis = '0;
      want    = '0;
      for (int i = 0; i < N; i++) begin
         sreq = ie[i] || of[i] || h;
         if (m_run[i]) begin
            if (sreq) begin
               exp_dis[i] = 1'b1;
               m_run[i]   = 1'b0;
               m_stop[i]  = cyc + 1;
            end
         end else if (cyc >= m_stop[i] + MS && !sreq) begin
            want[i] = 1'b1;
         end
      end
      done = 1'b0;
      for (int k = 0; k < N; k++) begin
         g = (m_ptr + k) % N;
         if (!done && want[g]) begin
            done      = 1'b1;
            exp_en[g] = 1'b1;
            m_run[g]  = 1'b1;
            m_ptr     = (g + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) exp_st[i] = !m_run[i] || exp_en[i];
   endtask

   task automatic cycle(input logic [N-1:0] ie, input logic [N-1:0] of, input logic h,
                        input logic r);
      @(negedge clk);
      cyc++;
      if (cyc < LOGN) begin
         en_log[cyc]  = ifc.clk_en;
         dis_log[cyc] = ifc.clk_dis;
      end
      chk("clk_en", ifc.clk_en, exp_en);
      chk("clk_dis", ifc.clk_dis, exp_dis);
      chk("stalled", ifc.stalled, exp_st);
      chk("en_dis_overlap", ifc.clk_en & ifc.clk_dis, '0);
      rst          = r;
      ifc.in_empty = ie;
      ifc.out_full = of;
      ifc.halt     = h;
      model_step(ie, of, h);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      int           t;
      int           npulse;
      logic [N-1:0] acc;
      logic [N-1:0] ie;
      logic [N-1:0] of;
      logic         h;

      model_reset();
      ifc.in_empty = '0;
      ifc.out_full = '0;
      ifc.halt     = 1'b0;
      repeat (3) cycle('0, '0, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b1);

      // quiet after reset release
      t = cyc;
      idle(20);
      acc = '0;
      for (int k = 1; k <= 20; k++) acc |= en_log[t+k] | dis_log[t+k];
      chk("idle_quiet", acc, '0);

      // single-cycle halt from ptr=0: all stop, restarts L1..L9 in order
      cycle('0, '0, 1'b1, 1'b1);
      t = cyc;
      idle(16);
      chk("halt_dis_all", dis_log[t+1], '1);
      for (int k = 0; k < N; k++) chk("halt_en_order", en_log[t+6+k], N'(1 << k));

      // one-cycle in_empty[2]: clk_dis at +1, clk_en at +6
      cycle(N'(9'b000000100), '0, 1'b0, 1'b1);
      t = cyc;
      idle(8);
      chk("empty2_dis", dis_log[t+1], N'(9'b000000100));
      chk("empty2_no_early_en", en_log[t+5], '0);
      chk("empty2_en", en_log[t+6], N'(9'b000000100));

      // ptr=3, layers 1 and 5 ready together: 5 first, then 1
      cycle(N'(9'b000100010), '0, 1'b0, 1'b1);
      t = cyc;
      idle(9);
      chk("rr_dis", dis_log[t+1], N'(9'b000100010));
      chk("rr_first", en_log[t+6], N'(9'b000100000));
      chk("rr_second", en_log[t+7], N'(9'b000000010));

      // ptr should now be 2: a halt restarts from layer index 2
      cycle('0, '0, 1'b1, 1'b1);
      t = cyc;
      idle(16);
      for (int k = 0; k < N; k++) chk("ptr_order", en_log[t+6+k], N'(1 << ((2 + k) % N)));

      // out_full[0] held 20 cycles: one stop, restart 1 cycle after it drops
      t = cyc + 1;
      repeat (20) cycle('0, N'(1), 1'b0, 1'b1);
      idle(3);
      chk("full0_dis", dis_log[t+1], N'(1));
      npulse = 0;
      acc    = '0;
      for (int k = 1; k <= 21; k++) begin
         npulse += int'(dis_log[t+k][0]);
         if (k <= 20) acc[0] = acc[0] | en_log[t+k][0];
      end
      chk("full0_one_dis", N'(npulse), N'(1));
      chk("full0_no_early_en", acc, '0);
      chk("full0_en", en_log[t+21], N'(1));

      // async reset while layers are in HOLD
      cycle('0, '0, 1'b1, 1'b1);
      idle(2);
      chk("pre_rst_stalled", ifc.stalled, '1);
      #2 rst = 1'b0;
      #1;
      chk("rst_clk_en", ifc.clk_en, '0);
      chk("rst_clk_dis", ifc.clk_dis, '0);
      chk("rst_stalled", ifc.stalled, '0);
      model_reset();
      repeat (2) cycle('0, '0, 1'b0, 1'b0);
      cycle('0, '0, 1'b0, 1'b1);
      cycle(N'(9'b000010000), '0, 1'b0, 1'b1);
      t = cyc;
      idle(8);
      chk("post_rst_dis", dis_log[t+1], N'(9'b000010000));
      chk("post_rst_en", en_log[t+6], N'(9'b000010000));

      // sparse random stalls
      repeat (2000) begin
         for (int i = 0; i < N; i++) begin
            ie[i] = ($urandom_range(15) == 0);
            of[i] = ($urandom_range(19) == 0);
         end
         h = ($urandom_range(63) == 0);
         cycle(ie, of, h, 1'b1);
      end
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
